// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one byte-addressed, big-endian memory between the instruction-fetch
//   requester (I) and the load/store requester (D) with round-robin priority.
//   One transaction every three cycles: grant (G), memory read (G+1),
//   registered response (G+2). Illegal or out-of-range accesses are flagged
//   with err and never write memory.
//
// Ports
//   clk, rst                      clock, synchronous active-low reset
//   i_req/i_addr                  fetch request (held until i_gnt)
//   i_gnt/i_rvalid/i_rdata/i_err  fetch grant pulse and registered response
//   d_req/d_we/d_size/d_unsigned/d_addr/d_wdata  load/store request
//   d_gnt/d_rvalid/d_rdata/d_err  load/store grant pulse and registered response
//   mem_addr/mem_we/mem_be/mem_wdata  memory command, driven in the grant cycle
//   mem_rdata                     memory read data, one cycle after mem_addr
module mem_arbiter #(
   parameter int MEM_BYTES = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic        i_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [1:0]  d_size,
   input  logic        d_unsigned,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic [31:0] mem_addr,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Pointer encoding: which requester was granted last.
   localparam logic LAST_I = 1'b0;
   localparam logic LAST_D = 1'b1;

   localparam logic [32:0] MEM_LIMIT  = 33'(MEM_BYTES);
   localparam logic [31:0] I_ADDR_MAX = 32'(MEM_BYTES - 4);

   // Number of bytes touched by an access of the given size.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // Byte enables: the lowest address is bit 3.
   function automatic logic [3:0] store_be(input logic [1:0] size);
      case (size)
         2'b00:   return 4'b1000;
         2'b01:   return 4'b1100;
         default: return 4'b1111;
      endcase
   endfunction

   // Left-justify right-justified store data so its first byte lands at mem_addr.
   function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         2'b00:   return {wdata[7:0], 24'h000000};
         2'b01:   return {wdata[15:0], 16'h0000};
         default: return wdata;
      endcase
   endfunction

   // The addressed byte is always at the top of mem_rdata, so sub-word loads
   // take the upper bits and extend them.
   function automatic logic [31:0] load_extract(input logic [31:0] raw, input logic [1:0] size,
                                                input logic uns);
      case (size)
         2'b00:   return uns ? {24'h000000, raw[31:24]} : {{24{raw[31]}}, raw[31:24]};
         2'b01:   return uns ? {16'h0000, raw[31:16]} : {{16{raw[31]}}, raw[31:16]};
         default: return raw;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic        ptr_q, ptr_d;
   logic        sel_d_q, sel_d_d;      // transaction in flight belongs to D
   logic        err_q, err_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic        i_rvalid_q, i_rvalid_d;
   logic        i_err_q, i_err_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic        d_rvalid_q, d_rvalid_d;
   logic        d_err_q, d_err_d;
   logic [31:0] d_rdata_q, d_rdata_d;

   logic [32:0] d_last_s;
   logic        d_bad_s;
   logic        i_bad_s;
   logic        win_d_s;
   logic        win_i_s;

   // Legality of the presented requests; 33-bit end address so huge addresses cannot wrap.
   always_comb begin
      d_last_s = {1'b0, d_addr} + {30'd0, size_bytes(d_size)} - 33'd1;
      d_bad_s  = (d_size == 2'b11) || ({1'b0, d_addr} >= MEM_LIMIT) || (d_last_s >= MEM_LIMIT);
      i_bad_s  = (i_addr[1:0] != 2'b00) || (i_addr > I_ADDR_MAX);
      // On a tie the requester not granted last wins. Gated by rst so nothing
      // is granted while reset is asserted.
      win_d_s  = rst && d_req && (!i_req || (ptr_q == LAST_I));
      win_i_s  = rst && i_req && (!d_req || (ptr_q == LAST_D));
   end

   // Next-state, grant/memory command and response computation.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      sel_d_d    = sel_d_q;
      err_d      = err_q;
      we_d       = we_q;
      size_d     = size_q;
      uns_d      = uns_q;
      i_rvalid_d = 1'b0;
      i_err_d    = 1'b0;
      i_rdata_d  = 32'h00000000;
      d_rvalid_d = 1'b0;
      d_err_d    = 1'b0;
      d_rdata_d  = 32'h00000000;
      i_gnt      = 1'b0;
      d_gnt      = 1'b0;
      mem_addr   = 32'h00000000;
      mem_we     = 1'b0;
      mem_be     = 4'b0000;
      mem_wdata  = 32'h00000000;
      case (state_q)
         IDLE: begin
            if (win_d_s) begin
               d_gnt    = 1'b1;
               mem_addr = d_addr;
               sel_d_d  = 1'b1;
               err_d    = d_bad_s;
               we_d     = d_we;
               size_d   = d_size;
               uns_d    = d_unsigned;
               ptr_d    = LAST_D;
               state_d  = WAIT;
               if (d_we && !d_bad_s) begin
                  mem_we    = 1'b1;
                  mem_be    = store_be(d_size);
                  mem_wdata = store_data(d_size, d_wdata);
               end else begin
                  mem_we    = 1'b0;
               end
            end else if (win_i_s) begin
               i_gnt    = 1'b1;
               mem_addr = i_addr;
               sel_d_d  = 1'b0;
               err_d    = i_bad_s;
               we_d     = 1'b0;
               ptr_d    = LAST_I;
               state_d  = WAIT;
            end else begin
               state_d  = IDLE;
            end
         end
         WAIT: begin
            state_d = RESP;
            if (sel_d_q) begin
               d_rvalid_d = 1'b1;
               d_err_d    = err_q;
               d_rdata_d  = (err_q || we_q) ? 32'h00000000 : load_extract(mem_rdata, size_q, uns_q);
            end else begin
               i_rvalid_d = 1'b1;
               i_err_d    = err_q;
               i_rdata_d  = err_q ? 32'h00000000 : mem_rdata;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, pointer, captured request attributes and registered responses.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         ptr_q      <= LAST_I;
         sel_d_q    <= 1'b0;
         err_q      <= 1'b0;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         uns_q      <= 1'b0;
         i_rvalid_q <= 1'b0;
         i_err_q    <= 1'b0;
         i_rdata_q  <= 32'h00000000;
         d_rvalid_q <= 1'b0;
         d_err_q    <= 1'b0;
         d_rdata_q  <= 32'h00000000;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         sel_d_q    <= sel_d_d;
         err_q      <= err_d;
         we_q       <= we_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         i_rvalid_q <= i_rvalid_d;
         i_err_q    <= i_err_d;
         i_rdata_q  <= i_rdata_d;
         d_rvalid_q <= d_rvalid_d;
         d_err_q    <= d_err_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign i_rvalid = i_rvalid_q;
   assign i_err    = i_err_q;
   assign i_rdata  = i_rdata_q;
   assign d_rvalid = d_rvalid_q;
   assign d_err    = d_err_q;
   assign d_rdata  = d_rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single byte-addressed, big-endian program/data memory between the instruction-fetch requester (I) and the load/store requester (D) of the RV32I core. Grants one requester per transaction using round-robin priority and drives the memory's address, write-enable, byte-enable and write-data lines. For D loads it extracts and sign- or zero-extends byte/half/word results. It rejects illegal sizes and out-of-range or misaligned accesses without touching memory.

## Interface
- MEM_BYTES, 256, memory size in bytes; legal byte addresses 0..MEM_BYTES-1
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low (block resets on a clk edge with rst==0)
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  32  fetch byte address
- i_gnt  out  1  one-cycle grant pulse for I
- i_rvalid  out  1  one-cycle response pulse for I
- i_rdata  out  32  fetched word, valid with i_rvalid
- i_err  out  1  fetch error flag, valid with i_rvalid
- d_req  in  1  data request; held with all d_* inputs stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- d_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-justified
- d_gnt, d_rvalid, d_err  out  1  grant, response and error for D, same rules as I
- d_rdata  out  32  load result; 0 for stores and errors
- mem_addr  out  32  memory byte address
- mem_we  out  1  memory write strobe
- mem_be  out  4  byte enables; bit 3 = byte at mem_addr, bit 0 = byte at mem_addr+3
- mem_wdata  out  32  write data; bits 31:24 go to mem_addr
- mem_rdata  in  32  memory read data, 1-cycle registered latency; bits 31:24 = byte at the address presented in the previous cycle

## Operation
- FSM states: IDLE, WAIT, RESP. Grants are issued only in IDLE. IDLE→WAIT on any grant. WAIT→RESP always. RESP→IDLE always.
- Arbitration in IDLE:
  - Only one requester active: it is granted.
  - Both active: the requester not granted last wins.
  - The last-granted pointer resets to I, so D wins the first tie after reset.
  - A requester may drop req before being granted; nothing is issued for it.
- Grant cycle G:
  - gnt=1 and mem_addr = granted address.
  - For a legal D store: mem_we=1 in cycle G only.
  - mem_we=0 in all other cycles and whenever an error is detected.
- Store mapping:
  - byte: mem_be=1000, mem_wdata={wdata[7:0],24'b0}
  - half: mem_be=1100, mem_wdata={wdata[15:0],16'b0}
  - word: mem_be=1111, mem_wdata=wdata
- Load extraction in WAIT:
  - byte: source mem_rdata[31:24]
  - half: source mem_rdata[31:16]
  - word: source mem_rdata
  - Extension per d_unsigned, using values captured at G.
  - Result is registered into d_rdata.
- Fetch: i_rdata = mem_rdata (word).
- Errors, decided at G and captured; no memory write occurs:
  - D: d_size==11, d_addr ≥ MEM_BYTES, or d_addr + bytes − 1 ≥ MEM_BYTES.
  - I: i_addr[1:0]≠0, or i_addr > MEM_BYTES−4.
  - On error: rdata=0 and err=1 in RESP.
- Responses: rvalid/rdata/err are asserted only in RESP, only to the requester granted at G. Stores also pulse d_rvalid as an acknowledge, with d_rdata=0.

## Timing
- Grant at G, memory read data at G+1, response at G+2, next grant no earlier than G+3. Peak throughput is 1 transaction per 3 cycles.
- All outputs other than gnt, mem_addr, mem_we, mem_be and mem_wdata are registered.
- Reset (rst==0 at an edge), from any state:
  - State → IDLE; the in-flight transaction is dropped with no response.
  - Pointer → I.
  - i_rvalid, d_rvalid, i_err, d_err → 0; i_rdata, d_rdata → 0.
  - While rst==0: gnt=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
- Requests are sampled in the same cycle as rst is released only if rst is already 1 at that edge. The first grant is possible in the cycle after release.

## Test plan
- Memory bytes 8..11 = 80,12,34,56. D load word at 8 → d_gnt at G, d_rvalid at G+2, d_rdata=0x80123456, d_err=0.
- Same memory contents:
  - signed byte at 8 → 0xFFFFFF80
  - unsigned byte at 8 → 0x00000080
  - signed half at 9 → 0x00001234
  - unsigned half at 8 → 0x00008012
- i_req and d_req held high from reset release → grants alternate D, I, D, I at cycles 0, 3, 6, 9 after release. Each rvalid reaches only its own requester.
- D store byte, addr 20, wdata 0xAABBCCDD → mem_we=1, mem_be=1000, mem_wdata=0xDD000000 at G; d_rvalid at G+2. A following word load at 20 (bytes 21..23 zero) → 0xDD000000.
- D load word at 254, D size 11, and I fetch at 6 → err=1 at G+2, rdata=0, mem_we=0 throughout. A store at 255 with size word leaves memory unchanged.
- rst driven low during WAIT → no rvalid two cycles later, all outputs 0. After release a new D request is granted in the next cycle and completes normally.
